// File: rtl/regfile_access_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_access_arbiter_if
//   Bundles the two requester handshakes and the shared register file port
//   used by regfile_access_arbiter.
//
//   Requester side (per requester n = 0/1):
//     req_valid_n, req_write_n, req_addr_n, req_wdata_n  -> arbiter
//     req_ready_n, rsp_valid_n, rsp_rdata_n, rsp_err_n    <- arbiter
//   Register file side:
//     rf_write_enable, rf_write_address, rf_write_data    <- arbiter
//     rf_read_address                                     <- arbiter
//     rf_read_data (combinational for rf_read_address)    -> arbiter
//
//   Modports:
//     slave  : the arbiter
//     master : the environment (clients plus register file)
// -----------------------------------------------------------------------------
interface regfile_access_arbiter_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 2
);
   logic              req_valid_0;
   logic              req_write_0;
   logic [ADDR_W-1:0] req_addr_0;
   logic [DATA_W-1:0] req_wdata_0;
   logic              req_ready_0;
   logic              rsp_valid_0;
   logic [DATA_W-1:0] rsp_rdata_0;
   logic              rsp_err_0;

   logic              req_valid_1;
   logic              req_write_1;
   logic [ADDR_W-1:0] req_addr_1;
   logic [DATA_W-1:0] req_wdata_1;
   logic              req_ready_1;
   logic              rsp_valid_1;
   logic [DATA_W-1:0] rsp_rdata_1;
   logic              rsp_err_1;

   logic              rf_write_enable;
   logic [ADDR_W-1:0] rf_write_address;
   logic [DATA_W-1:0] rf_write_data;
   logic [ADDR_W-1:0] rf_read_address;
   logic [DATA_W-1:0] rf_read_data;

   modport slave (
      input  req_valid_0, req_write_0, req_addr_0, req_wdata_0,
      output req_ready_0, rsp_valid_0, rsp_rdata_0, rsp_err_0,
      input  req_valid_1, req_write_1, req_addr_1, req_wdata_1,
      output req_ready_1, rsp_valid_1, rsp_rdata_1, rsp_err_1,
      output rf_write_enable, rf_write_address, rf_write_data, rf_read_address,
      input  rf_read_data
   );

   modport master (
      output req_valid_0, req_write_0, req_addr_0, req_wdata_0,
      input  req_ready_0, rsp_valid_0, rsp_rdata_0, rsp_err_0,
      output req_valid_1, req_write_1, req_addr_1, req_wdata_1,
      input  req_ready_1, rsp_valid_1, rsp_rdata_1, rsp_err_1,
      input  rf_write_enable, rf_write_address, rf_write_data, rf_read_address,
      output rf_read_data
   );
endinterface

// File: rtl/regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_access_arbiter
//   Shares one register file write port and one read port between two
//   requesters. Each accepted request runs IDLE -> ISSUE -> RESP, so a
//   response pulse appears two cycles after the handshake edge and at most
//   one operation completes every three cycles.
//
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : regfile_access_arbiter_if.slave (requester handshakes and
//             register file port)
//     busy  : FSM is not in IDLE
//
//   Build option:
//     REGFILE_ARB_FIXED_PRIORITY_EN  defined   -> requester 0 wins every tie
//                                    undefined -> round-robin on ties
// -----------------------------------------------------------------------------
module regfile_access_arbiter #(
   parameter int DATA_W   = 4,
   parameter int ADDR_W   = 2,
   parameter int NUM_REGS = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   regfile_access_arbiter_if.slave       bus,
   output logic                          busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RESP  = 2'd2;

   logic [1:0]        state;
   logic              lat_write;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic              lat_id;
   logic              lat_err;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] rd_addr_q;

   logic              idle;
   logic              tie_pick_1;
   logic              win_1;
   logic              handshake;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_oob;

   assign idle = (state == ST_IDLE);
   assign busy = ~idle;

   // ---------------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------------
`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
   assign tie_pick_1 = 1'b0;
`else
   // last_grant holds the id of the most recent winner; the other side takes
   // the next tie. Reset to 1 so requester 0 wins the first tie.
   logic last_grant;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)         last_grant <= 1'b1;
      else if (handshake) last_grant <= win_1;
   end

   assign tie_pick_1 = ~last_grant;
`endif

   // win_1 is only meaningful when at least one requester is valid.
   assign win_1     = bus.req_valid_1 & (~bus.req_valid_0 | tie_pick_1);
   assign handshake = idle & (bus.req_valid_0 | bus.req_valid_1);

   assign bus.req_ready_0 = idle & bus.req_valid_0 & ~win_1;
   assign bus.req_ready_1 = idle & win_1;

   assign sel_write = win_1 ? bus.req_write_1 : bus.req_write_0;
   assign sel_addr  = win_1 ? bus.req_addr_1  : bus.req_addr_0;
   assign sel_wdata = win_1 ? bus.req_wdata_1 : bus.req_wdata_0;
   assign sel_oob   = (32'(sel_addr) >= 32'(NUM_REGS));

   // ---------------------------------------------------------------------------
   // FSM and request latches
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_id    <= 1'b0;
         lat_err   <= 1'b0;
         rdata_q   <= '0;
         rd_addr_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (handshake) begin
                  state     <= ST_ISSUE;
                  lat_write <= sel_write;
                  lat_addr  <= sel_addr;
                  lat_wdata <= sel_wdata;
                  lat_id    <= win_1;
                  lat_err   <= sel_oob;
                  // Read address is loaded here so it is already stable
                  // for the whole ISSUE cycle, then simply held afterwards.
                  if (!sel_write && !sel_oob) rd_addr_q <= sel_addr;
               end
            end
            ST_ISSUE: begin
               state   <= ST_RESP;
               rdata_q <= (!lat_write && !lat_err) ? bus.rf_read_data : '0;
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Register file port
   // ---------------------------------------------------------------------------
   // Write strobe is decoded from state so an asynchronous reset during
   // ISSUE removes it immediately.
   assign bus.rf_write_enable  = (state == ST_ISSUE) & lat_write & ~lat_err;
   assign bus.rf_write_address = lat_addr;
   assign bus.rf_write_data    = lat_wdata;
   assign bus.rf_read_address  = rd_addr_q;

   // ---------------------------------------------------------------------------
   // Responses: only the latched winner sees anything during RESP
   // ---------------------------------------------------------------------------
   logic in_resp;
   assign in_resp = (state == ST_RESP);

   assign bus.rsp_valid_0 = in_resp & ~lat_id;
   assign bus.rsp_valid_1 = in_resp &  lat_id;
   assign bus.rsp_err_0   = in_resp & ~lat_id & lat_err;
   assign bus.rsp_err_1   = in_resp &  lat_id & lat_err;
   assign bus.rsp_rdata_0 = bus.rsp_valid_0 ? rdata_q : '0;
   assign bus.rsp_rdata_1 = bus.rsp_valid_1 ? rdata_q : '0;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_arbiter
//   Directed bench for regfile_access_arbiter built with NUM_REGS=3 so that
//   address 3 is out of range. A small register file model sits on the rf
//   port; expected values are hand-computed per step.
// -----------------------------------------------------------------------------
module tb_regfile_access_arbiter;

   localparam int DATA_W   = 4;
   localparam int ADDR_W   = 2;
   localparam int NUM_REGS = 3;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic busy;

   int n_cmp = 0;
   int n_bad = 0;

   regfile_access_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   regfile_access_arbiter #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_REGS(NUM_REGS)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.slave),
      .busy (busy)
   );

   always #5 clock = ~clock;

   // Register file model: combinational read, write on rising edge.
   logic [DATA_W-1:0] mem [0:3];
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else if (bus.rf_write_enable) begin
         mem[bus.rf_write_address] <= bus.rf_write_data;
      end
   end
   assign bus.rf_read_data = mem[bus.rf_read_address];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Expected grant sequence for the contention test.
`ifdef REGFILE_ARB_FIXED_PRIORITY_EN
   logic [3:0] exp_win1 = 4'b0000;
`else
   logic [3:0] exp_win1 = 4'b1010;   // bit k = requester 1 wins round k
`endif

   initial begin
      bus.req_valid_0 = 0; bus.req_write_0 = 0; bus.req_addr_0 = '0; bus.req_wdata_0 = '0;
      bus.req_valid_1 = 0; bus.req_write_1 = 0; bus.req_addr_1 = '0; bus.req_wdata_1 = '0;

      // ---- reset state
      #1;
      chk("rst_busy",   busy, 0);
      chk("rst_ready0", bus.req_ready_0, 0);
      chk("rst_ready1", bus.req_ready_1, 0);
      chk("rst_rspv0",  bus.rsp_valid_0, 0);
      chk("rst_rspv1",  bus.rsp_valid_1, 0);
      chk("rst_we",     bus.rf_write_enable, 0);
      chk("rst_wa",     bus.rf_write_address, 0);
      chk("rst_wd",     bus.rf_write_data, 0);
      chk("rst_ra",     bus.rf_read_address, 0);
      #11 reset = 1'b1;
      tick();

      // ---- requester 0 writes addr 2 = 0xA
      bus.req_valid_0 = 1; bus.req_write_0 = 1; bus.req_addr_0 = 2; bus.req_wdata_0 = 4'hA;
      #1;
      chk("w_ready0", bus.req_ready_0, 1);
      chk("w_ready1", bus.req_ready_1, 0);
      tick();
      bus.req_valid_0 = 0;
      chk("w_issue_we",   bus.rf_write_enable, 1);
      chk("w_issue_wa",   bus.rf_write_address, 2);
      chk("w_issue_wd",   bus.rf_write_data, 4'hA);
      chk("w_issue_busy", busy, 1);
      chk("w_issue_rspv", bus.rsp_valid_0, 0);
      tick();
      chk("w_resp_we",    bus.rf_write_enable, 0);
      chk("w_resp_rspv0", bus.rsp_valid_0, 1);
      chk("w_resp_rdata", bus.rsp_rdata_0, 0);
      chk("w_resp_err",   bus.rsp_err_0, 0);
      chk("w_resp_rspv1", bus.rsp_valid_1, 0);
      tick();
      chk("w_idle_rspv0", bus.rsp_valid_0, 0);
      chk("w_idle_busy",  busy, 0);

      // ---- requester 1 reads addr 2
      bus.req_valid_1 = 1; bus.req_write_1 = 0; bus.req_addr_1 = 2;
      #1;
      chk("r_ready1", bus.req_ready_1, 1);
      tick();
      bus.req_valid_1 = 0;
      chk("r_issue_ra", bus.rf_read_address, 2);
      chk("r_issue_we", bus.rf_write_enable, 0);
      tick();
      chk("r_resp_rspv1", bus.rsp_valid_1, 1);
      chk("r_resp_rdata", bus.rsp_rdata_1, 4'hA);
      chk("r_resp_err",   bus.rsp_err_1, 0);
      chk("r_resp_rspv0", bus.rsp_valid_0, 0);
      tick();
      chk("r_idle_ra_hold", bus.rf_read_address, 2);
      chk("r_idle_rspv1",   bus.rsp_valid_1, 0);

      // ---- contention: 0 writes addr1=5, 1 reads addr1, both always valid
      bus.req_valid_0 = 1; bus.req_write_0 = 1; bus.req_addr_0 = 1; bus.req_wdata_0 = 4'h5;
      bus.req_valid_1 = 1; bus.req_write_1 = 0; bus.req_addr_1 = 1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr%0d_ready0", k), bus.req_ready_0, {31'd0, ~exp_win1[k]});
         chk($sformatf("rr%0d_ready1", k), bus.req_ready_1, {31'd0,  exp_win1[k]});
         tick();
         chk($sformatf("rr%0d_issue_r0", k), bus.req_ready_0, 0);
         chk($sformatf("rr%0d_issue_r1", k), bus.req_ready_1, 0);
         tick();
         chk($sformatf("rr%0d_rspv0", k), bus.rsp_valid_0, {31'd0, ~exp_win1[k]});
         chk($sformatf("rr%0d_rspv1", k), bus.rsp_valid_1, {31'd0,  exp_win1[k]});
         chk($sformatf("rr%0d_rdata1", k), bus.rsp_rdata_1, exp_win1[k] ? 32'h5 : 32'h0);
         tick();
      end
      bus.req_valid_0 = 0; bus.req_valid_1 = 0;

      // ---- out-of-range write to addr 3
      bus.req_valid_0 = 1; bus.req_write_0 = 1; bus.req_addr_0 = 3; bus.req_wdata_0 = 4'hF;
      #1;
      chk("oob_ready0", bus.req_ready_0, 1);
      tick();
      bus.req_valid_0 = 0;
      chk("oob_issue_we", bus.rf_write_enable, 0);
      tick();
      chk("oob_rspv0", bus.rsp_valid_0, 1);
      chk("oob_err0",  bus.rsp_err_0, 1);
      chk("oob_rdata", bus.rsp_rdata_0, 0);
      tick();
      chk("oob_err_clr", bus.rsp_err_0, 0);

      // ---- reset during ISSUE of a write
      bus.req_valid_0 = 1; bus.req_write_0 = 1; bus.req_addr_0 = 0; bus.req_wdata_0 = 4'h3;
      tick();
      bus.req_valid_0 = 0;
      chk("mid_issue_we", bus.rf_write_enable, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_we_cut", bus.rf_write_enable, 0);
      chk("mid_busy",   busy, 0);
      tick();
      chk("mid_rspv0_a", bus.rsp_valid_0, 0);
      tick();
      chk("mid_rspv0_b", bus.rsp_valid_0, 0);
      chk("mid_rspv1",   bus.rsp_valid_1, 0);
      #2 reset = 1'b1;

      // ---- tie after reset goes to 0; requester 1 waits while busy
      bus.req_valid_0 = 1; bus.req_write_0 = 1; bus.req_addr_0 = 0; bus.req_wdata_0 = 4'h7;
      bus.req_valid_1 = 1; bus.req_write_1 = 0; bus.req_addr_1 = 0;
      #1;
      chk("post_ready0", bus.req_ready_0, 1);
      chk("post_ready1", bus.req_ready_1, 0);
      tick();
      bus.req_valid_0 = 0;
      chk("wait_issue_r1", bus.req_ready_1, 0);
      tick();
      chk("wait_resp_r1",   bus.req_ready_1, 0);
      chk("wait_resp_rsp0", bus.rsp_valid_0, 1);
      tick();
      chk("wait_idle_r1", bus.req_ready_1, 1);
      tick();
      bus.req_valid_1 = 0;
      chk("wait_issue_ra", bus.rf_read_address, 0);
      tick();
      chk("wait_rspv1",  bus.rsp_valid_1, 1);
      chk("wait_rdata1", bus.rsp_rdata_1, 4'h7);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
